ldpc_pin_host: RTL and testbench

- Host-side initiator for the ldpcEncDec serial pin port: select bus, direction, serial data in, serial data out.
- Turns parallel command/response handshakes into bit-serial pin transfers.
- Used on the FPGA/bring-up side and as a synthesizable bench driver.
- Drives the device's P_in_out_sel, P_inputnoutput and P_input; samples PO_output.

---
 rtl/ldpc_pin_pkg.sv | 32 +++
 rtl/ldpc_pin_shifter.sv | 38 +++
 rtl/ldpc_pin_host.sv | 179 +++++++++++++++++
 tb/tb_ldpc_pin_host.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pin_pkg.sv
// ldpc_pin_pkg: shared types and constants for the ldpcEncDec pin-port host.
//   state_t          - host FSM state encoding
//   SEL_IDLE         - select value meaning "no register selected"
//   DIR_WRITE/READ   - values driven on the direction pin
//   DEFAULT_DATA_W/ADDR_W - default transfer and select widths
//   max3()           - helper used to size the shared down-counter
package ldpc_pin_pkg;

   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_ADDR_W = 16;
   localparam int SEL_IDLE       = 0;

   localparam logic DIR_WRITE = 1'b1;
   localparam logic DIR_READ  = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_SHIFT_WR = 3'd2,
      ST_WAIT_RD  = 3'd3,
      ST_SHIFT_RD = 3'd4,
      ST_GAP      = 3'd5,
      ST_RESP     = 3'd6
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ldpc_pin_shifter.sv
// ldpc_pin_shifter: W-bit shift register shared by the write and read paths.
//   clk, rst   - clock, synchronous active-high reset
//   load       - capture load_data (highest priority)
//   shift_in   - shift left, in_bit enters at the LSB (read path)
//   shift_out  - shift left, zero enters at the LSB (write path; msb is the bit on the wire)
//   data       - current register contents
//   msb        - data[W-1]
module ldpc_pin_shifter
   import ldpc_pin_pkg::*;
#(
   parameter int W = DEFAULT_DATA_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         shift_out,
   input  logic         shift_in,
   input  logic         in_bit,
   output logic [W-1:0] data,
   output logic         msb
);

   always_ff @(posedge clk) begin
      if (rst) begin
         data <= '0;
      end else if (load) begin
         data <= load_data;
      end else if (shift_in) begin
         data <= {data[W-2:0], in_bit};
      end else if (shift_out) begin
         data <= {data[W-2:0], 1'b0};
      end
   end

   assign msb = data[W-1];

endmodule

// File: rtl/ldpc_pin_host.sv
// ldpc_pin_host: host-side initiator for the ldpcEncDec serial pin port.
// Converts one parallel command into one bit-serial frame on the pins and
// returns one parallel response.
//   wb_clk_i, wb_rst_i          - clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata - command channel (addr 0 is rejected)
//   rsp_valid/ready/rdata/err        - response channel (rdata 0 for writes)
//   busy                        - FSM is not idle
//   pin_sel, pin_dir, pin_data  - to P_in_out_sel, P_inputnoutput, P_input
//   pin_po                      - from PO_output
// Handshakes: a channel transfers on the rising edge where valid && ready are
// both high; once raised, rsp_valid stays high with rsp_rdata/rsp_err stable
// until that transfer happens. cmd_ready is high only in IDLE.
// All outputs are registered; the FSM state is visible as the signal 'state'.
module ldpc_pin_host
   import ldpc_pin_pkg::*;
#(
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int ADDR_W  = DEFAULT_ADDR_W,
   parameter int RD_LAT  = 2,
   parameter int GAP_CYC = 2
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic [ADDR_W-1:0] pin_sel,
   output logic              pin_dir,
   output logic              pin_data,
   input  logic              pin_po
);

   localparam int CNT_MAX   = max3(DATA_W, RD_LAT, GAP_CYC);
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam int RD_LAT_M1 = (RD_LAT > 0) ? RD_LAT - 1 : 0;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              wr_q;

   logic              sr_load;
   logic              sr_shift_out;
   logic              sr_shift_in;
   logic [DATA_W-1:0] sr_data;
   logic              sr_msb;

   // The word is loaded at accept. On the write path the MSB is copied to
   // pin_data at each edge and the register shifts at the same time, so the
   // register always holds the next bit to send at its top.
   assign sr_load      = (state == ST_IDLE) && cmd_valid;
   assign sr_shift_out = ((state == ST_SETUP) && wr_q) ||
                         ((state == ST_SHIFT_WR) && (cnt != '0));
   assign sr_shift_in  = (state == ST_SHIFT_RD);

   ldpc_pin_shifter #(.W(DATA_W)) u_shifter (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .load      (sr_load),
      .load_data (cmd_wdata),
      .shift_out (sr_shift_out),
      .shift_in  (sr_shift_in),
      .in_bit    (pin_po),
      .data      (sr_data),
      .msb       (sr_msb)
   );

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         wr_q      <= 1'b0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
         busy      <= 1'b0;
         pin_sel   <= ADDR_W'(SEL_IDLE);
         pin_dir   <= DIR_READ;
         pin_data  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  wr_q      <= cmd_write;
                  if (cmd_addr == ADDR_W'(SEL_IDLE)) begin
                     // Reserved select: answer with an error, never touch the pins.
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     state    <= ST_SETUP;
                     pin_sel  <= cmd_addr;
                     pin_dir  <= cmd_write ? DIR_WRITE : DIR_READ;
                     pin_data <= 1'b0;
                  end
               end
            end
            ST_SETUP: begin
               if (wr_q) begin
                  state    <= ST_SHIFT_WR;
                  cnt      <= CNT_W'(DATA_W - 1);
                  pin_data <= sr_msb;
               end else if (RD_LAT == 0) begin
                  state <= ST_SHIFT_RD;
                  cnt   <= CNT_W'(DATA_W - 1);
               end else begin
                  state <= ST_WAIT_RD;
                  cnt   <= CNT_W'(RD_LAT_M1);
               end
            end
            ST_SHIFT_WR: begin
               if (cnt == '0) begin
                  state    <= ST_GAP;
                  cnt      <= CNT_W'(GAP_CYC - 1);
                  pin_sel  <= ADDR_W'(SEL_IDLE);
                  pin_dir  <= DIR_READ;
                  pin_data <= 1'b0;
               end else begin
                  cnt      <= cnt - 1'b1;
                  pin_data <= sr_msb;
               end
            end
            ST_WAIT_RD: begin
               if (cnt == '0) begin
                  state <= ST_SHIFT_RD;
                  cnt   <= CNT_W'(DATA_W - 1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_SHIFT_RD: begin
               // The shifter captures pin_po on this same edge.
               if (cnt == '0) begin
                  state    <= ST_GAP;
                  cnt      <= CNT_W'(GAP_CYC - 1);
                  pin_sel  <= ADDR_W'(SEL_IDLE);
                  pin_dir  <= DIR_READ;
                  pin_data <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt == '0) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= wr_q ? '0 : sr_data;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state     <= ST_IDLE;
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ldpc_pin_host.sv
// tb_ldpc_pin_host: scoreboard bench for ldpc_pin_host with a behavioural
// model of the pin-port device (frame decoder and read-data responder).
module tb_ldpc_pin_host;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 16;
   localparam int RD_LAT  = 2;
   localparam int GAP_CYC = 2;

   // ---------------- clock / reset ----------------
   logic              clk = 1'b0;
   logic              wb_rst_i = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic              cmd_write = 1'b0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [DATA_W-1:0] cmd_wdata = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              busy;
   logic [ADDR_W-1:0] pin_sel;
   logic              pin_dir;
   logic              pin_data;
   logic              pin_po = 1'b0;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ldpc_pin_host #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .GAP_CYC(GAP_CYC)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (wb_rst_i),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .pin_sel   (pin_sel),
      .pin_dir   (pin_dir),
      .pin_data  (pin_data),
      .pin_po    (pin_po)
   );

   // ---------------- scoreboard state ----------------
   typedef struct {
      logic [DATA_W-1:0] rdata;
      logic              err;
      int                due;
   } rsp_t;

   typedef struct {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } frm_t;

   rsp_t              exp_q[$];
   frm_t              frame_q[$];
   logic [DATA_W-1:0] dev_q[$];

   int vectors = 0;
   int errors  = 0;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference timing: cycles from accept to the rise of rsp_valid.
   function automatic int model_latency(input logic wr, input logic [ADDR_W-1:0] addr);
      if (addr == 0) return 1;
      return 1 + 1 + (wr ? 0 : RD_LAT) + DATA_W + GAP_CYC;
   endfunction

   // Response backpressure control
   int bp_until = 0;
   bit rr_rand  = 1'b0;

   always @(posedge clk) begin
      #1;
      if (cyc < bp_until)   rsp_ready = 1'b0;
      else if (rr_rand)     rsp_ready = ($urandom_range(0, 3) != 0);
      else                  rsp_ready = 1'b1;
   end

   // ---------------- driver tasks ----------------
   // Offers a command and leaves cmd_valid high; returns the accept cycle.
   task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rword,
                        output int t_acc);
      rsp_t e;
      frm_t f;
      bit   got;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_valid = 1'b1;
      got   = 1'b0;
      t_acc = -1;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (cmd_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         check("accept_timeout", 64'd0, 64'd1);
         cmd_valid = 1'b0;
      end else begin
         t_acc   = cyc;
         e.rdata = (addr == 0 || wr) ? '0 : rword;
         e.err   = (addr == 0);
         e.due   = t_acc + model_latency(wr, addr);
         exp_q.push_back(e);
         if (addr != 0) begin
            f.wr = wr; f.addr = addr; f.data = wdata;
            frame_q.push_back(f);
            if (!wr) dev_q.push_back(rword);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && frame_q.size() == 0 && cmd_ready && !rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("drain_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
   endtask

   // ---------------- response monitor ----------------
   bit                prev_valid = 1'b0;
   bit                hs_prev = 1'b0;
   logic [DATA_W-1:0] held_data;
   logic              held_err;
   rsp_t              got_e;

   always @(negedge clk) begin
      if (wb_rst_i) begin
         prev_valid = 1'b0;
         hs_prev    = 1'b0;
      end else begin
         if (hs_prev) begin
            check("rsp_drop_after_hs", rsp_valid, 0);
            check("cmd_ready_after_hs", cmd_ready, 1);
         end
         if (rsp_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
               got_e = exp_q.pop_front();
               check("rsp_rdata", rsp_rdata, got_e.rdata);
               check("rsp_err", rsp_err, got_e.err);
               check("rsp_latency", cyc, got_e.due);
               check("rsp_cmd_ready_low", cmd_ready, 0);
            end
            held_data = rsp_rdata;
            held_err  = rsp_err;
         end else if (rsp_valid) begin
            check("rsp_hold_rdata", rsp_rdata, held_data);
            check("rsp_hold_err", rsp_err, held_err);
            check("rsp_hold_cmd_ready", cmd_ready, 0);
            check("rsp_hold_pin_sel", pin_sel, 0);
         end
         hs_prev    = rsp_valid && rsp_ready;
         prev_valid = rsp_valid;
      end
   end

   // ---------------- device model / frame monitor ----------------
   bit                in_frame = 1'b0;
   bit                have_prev = 1'b0;
   bit                stable;
   int                idx;
   int                zero_run = 0;
   int                bit_i;
   logic [ADDR_W-1:0] fsel;
   logic              fdir;
   logic [DATA_W-1:0] wbits;
   logic [DATA_W-1:0] rword;
   frm_t              got_f;

   always @(negedge clk) begin
      if (wb_rst_i) begin
         in_frame  = 1'b0;
         have_prev = 1'b0;
         zero_run  = 0;
         pin_po    = 1'b0;
      end else if (pin_sel == 0) begin
         check("idle_pins", {pin_dir, pin_data}, 0);
         pin_po = 1'b0;
         if (in_frame) begin
            in_frame = 1'b0;
            if (frame_q.size() == 0) begin
               check("unexpected_frame", 64'd1, 64'd0);
            end else begin
               got_f = frame_q.pop_front();
               check("frame_sel", fsel, got_f.addr);
               check("frame_dir", fdir, got_f.wr);
               check("frame_len", idx + 1, got_f.wr ? 1 + DATA_W : 1 + RD_LAT + DATA_W);
               check("frame_stable", stable, 1);
               if (got_f.wr) check("frame_wdata", wbits, got_f.data);
            end
            have_prev = 1'b1;
            zero_run  = 0;
         end
         zero_run++;
      end else begin
         if (!in_frame) begin
            if (have_prev) check("gap_between_frames", zero_run >= GAP_CYC + 1, 1);
            in_frame = 1'b1;
            idx      = 0;
            fsel     = pin_sel;
            fdir     = pin_dir;
            wbits    = '0;
            stable   = 1'b1;
            rword    = '0;
            if (!pin_dir && dev_q.size() != 0) rword = dev_q.pop_front();
         end else begin
            idx++;
         end
         if (pin_sel !== fsel || pin_dir !== fdir) stable = 1'b0;
         if (fdir && idx > 0) wbits = {wbits[DATA_W-2:0], pin_data};
         else if (pin_data) stable = 1'b0;
         // Device answers read bit i during frame cycle 1 + RD_LAT + i.
         bit_i = idx - 1 - RD_LAT;
         if (!fdir && bit_i >= 0 && bit_i < DATA_W) pin_po = rword[DATA_W-1-bit_i];
         else pin_po = 1'b0;
      end
   end

   // ---------------- stimulus ----------------
   int                t1, t2, t_rd;
   logic [ADDR_W-1:0] a;
   logic              w;

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_pin_sel", pin_sel, 0);
      check("reset_pins", {pin_dir, pin_data}, 0);
      check("reset_cmd_ready", cmd_ready, 1);
      check("reset_rsp", {rsp_valid, rsp_err, busy}, 0);
      check("reset_rdata", rsp_rdata, 0);
      @(posedge clk);
      #1;
      wb_rst_i = 1'b0;
      idle_cycles(2);

      // directed write
      issue(1'b1, 16'h0003, 32'hA5A5_0F0F, '0, t1);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("busy_in_setup", busy, 1);
      check("setup_sel", pin_sel, 16'h0003);
      wait_idle();

      // directed read
      issue(1'b0, 16'h0010, '0, 32'hDEAD_BEEF, t1);
      cmd_valid = 1'b0;
      wait_idle();

      // reserved address
      issue(1'b1, 16'h0000, $urandom, '0, t1);
      cmd_valid = 1'b0;
      wait_idle();

      // back-to-back with cmd_valid held high
      issue(1'b1, 16'h0042, $urandom, '0, t1);
      issue(1'b0, 16'h0077, '0, $urandom, t2);
      cmd_valid = 1'b0;
      check("b2b_second_accept", t2, t1 + model_latency(1'b1, 16'h0042) + 1);
      wait_idle();

      // backpressure on a read response
      issue(1'b0, 16'h0021, '0, $urandom, t_rd);
      cmd_valid = 1'b0;
      bp_until  = t_rd + model_latency(1'b0, 16'h0021) + 10;
      while (cyc < bp_until - 1) @(negedge clk);
      check("bp_rsp_held", rsp_valid, 1);
      check("bp_cmd_ready", cmd_ready, 0);
      wait_idle();

      // reset while shifting write bit 12
      issue(1'b1, 16'h0005, $urandom, '0, t1);
      cmd_valid = 1'b0;
      while (cyc < t1 + 2 + 12) begin
         @(posedge clk);
         #1;
      end
      wb_rst_i = 1'b1;
      exp_q.delete();
      frame_q.delete();
      dev_q.delete();
      @(posedge clk);
      #1;
      wb_rst_i = 1'b0;
      @(negedge clk);
      check("rst_mid_pins", {pin_sel, pin_dir, pin_data}, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_cmd_ready", cmd_ready, 1);
      check("rst_mid_rsp_valid", rsp_valid, 0);
      idle_cycles(4);
      issue(1'b1, 16'h0009, 32'h0000_0001, '0, t1);
      cmd_valid = 1'b0;
      wait_idle();

      // randomized traffic with random response backpressure
      rr_rand = 1'b1;
      for (int k = 0; k < 24; k++) begin
         w = $urandom_range(0, 1);
         a = ($urandom_range(0, 5) == 0) ? '0 : ADDR_W'($urandom_range(1, 16'hFFFF));
         issue(w, a, $urandom, $urandom, t1);
         if ($urandom_range(0, 1) == 1) begin
            cmd_valid = 1'b0;
            idle_cycles($urandom_range(0, 3));
         end
      end
      cmd_valid = 1'b0;
      rr_rand   = 1'b0;
      wait_idle();
      check("queues_empty", exp_q.size() + frame_q.size() + dev_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
